// File: rtl/mprj_wb_responder.sv
// mprj_wb_responder
//   Wishbone responder for the user project area. Decodes a 256-byte window
//   at BASE_ADR and provides CTRL/STATUS/SCRATCH/TIMER registers, a 32x32
//   buffer RAM at offsets 0x80-0xFC, programmable wait states per access and
//   a countdown timer whose expiry raises irq_o.
//
// Ports:
//   wb_clk_i   clock
//   wb_rst_i   synchronous active-high reset
//   wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i[3:0], wbs_adr_i[31:0],
//   wbs_dat_i[31:0]       Wishbone request from the management core
//   wbs_ack_o  one-cycle registered acknowledge
//   wbs_dat_o  read data, valid while ack is high, zero otherwise
//   irq_o      timer interrupt (pending & irq_en), registered
module mprj_wb_responder #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    localparam logic [5:0] W_CTRL    = 6'h00;
    localparam logic [5:0] W_STATUS  = 6'h01;
    localparam logic [5:0] W_SCRATCH = 6'h02;
    localparam logic [5:0] W_TIMER   = 6'h03;

    state_t      state;
    logic [3:0]  wcnt;

    // Request latched at transfer start (data path, not reset)
    logic [5:0]  lat_adr;
    logic        lat_we;
    logic [3:0]  lat_sel;
    logic [31:0] lat_dat;

    // Register file
    logic        irq_en;
    logic [3:0]  ws;
    logic [31:0] scratch;
    logic [31:0] timer;
    logic        pending;
    logic [7:0]  wr_cnt;

    logic [31:0] bufmem [32];
    logic [31:0] buf_q;
    logic [31:0] reg_q;
    logic        sel_buf_q;

    logic        hit;
    logic        to_ack;
    logic        commit;
    logic [5:0]  rd_word;
    logic [31:0] reg_rdata;

    logic        irq_en_d;
    logic [3:0]  ws_d;
    logic [31:0] scratch_d;
    logic [31:0] timer_d;
    logic        pending_d;
    logic        tmr_set;
    logic        tmr_clr;

    logic        unused_bits;
    assign unused_bits = &{1'b0, wbs_adr_i[1:0]};

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);

    // With ws=0 the ACK entry edge is the request edge itself, so the read
    // address must come straight from the bus while still in IDLE.
    assign rd_word = (state == IDLE) ? wbs_adr_i[7:2] : lat_adr;

    assign to_ack = ((state == IDLE) && hit && (ws == 4'd0)) ||
                    ((state == WAIT) && wbs_cyc_i && wbs_stb_i && (wcnt == 4'd1));

    // Writes take effect on the edge that ends ACK; reset on that edge wins.
    assign commit = (state == ACK) && lat_we && !wb_rst_i;

    always_comb begin
        reg_rdata = '0;
        case (rd_word)
            W_CTRL:    reg_rdata = {24'b0, ws, 3'b0, irq_en};
            W_STATUS:  reg_rdata = {16'b0, wr_cnt, 7'b0, pending};
            W_SCRATCH: reg_rdata = scratch;
            W_TIMER:   reg_rdata = timer;
            default:   reg_rdata = '0;
        endcase
    end

    always_comb begin
        irq_en_d  = irq_en;
        ws_d      = ws;
        scratch_d = scratch;
        timer_d   = timer;
        tmr_set   = 1'b0;
        tmr_clr   = 1'b0;
        if (commit && (lat_adr == W_CTRL) && lat_sel[0]) begin
            irq_en_d = lat_dat[0];
            ws_d     = lat_dat[7:4];
        end
        if (commit && (lat_adr == W_SCRATCH))
            scratch_d = byte_merge(scratch, lat_dat, lat_sel);
        // A load (even of 0) pre-empts the decrement, so it never sets pending.
        if (commit && (lat_adr == W_TIMER)) begin
            timer_d = byte_merge(timer, lat_dat, lat_sel);
        end else if (timer != 32'd0) begin
            timer_d = timer - 32'd1;
            tmr_set = (timer == 32'd1);
        end
        if (commit && (lat_adr == W_STATUS) && lat_sel[0] && lat_dat[0])
            tmr_clr = 1'b1;
        // Expiry beats a simultaneous W1C
        pending_d = tmr_set | (pending & ~tmr_clr);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wcnt      <= 4'd0;
            wbs_ack_o <= 1'b0;
            reg_q     <= '0;
            sel_buf_q <= 1'b0;
            irq_en    <= 1'b0;
            ws        <= 4'd0;
            scratch   <= '0;
            timer     <= '0;
            pending   <= 1'b0;
            wr_cnt    <= 8'd0;
            irq_o     <= 1'b0;
        end else begin
            wbs_ack_o <= to_ack;
            reg_q     <= to_ack ? reg_rdata : 32'd0;
            sel_buf_q <= to_ack & rd_word[5];
            case (state)
                IDLE: begin
                    if (hit) begin
                        wcnt  <= ws;
                        state <= (ws == 4'd0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (!(wbs_cyc_i && wbs_stb_i)) begin
                        state <= IDLE;
                    end else if (wcnt == 4'd1) begin
                        state <= ACK;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
            if (commit) wr_cnt <= wr_cnt + 8'd1;
            irq_en  <= irq_en_d;
            ws      <= ws_d;
            scratch <= scratch_d;
            timer   <= timer_d;
            pending <= pending_d;
            // Built from next-state values so irq_o moves on the same edge as pending
            irq_o   <= pending_d & irq_en_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if ((state == IDLE) && hit) begin
            lat_adr <= wbs_adr_i[7:2];
            lat_we  <= wbs_we_i;
            lat_sel <= wbs_sel_i;
            lat_dat <= wbs_dat_i;
        end
    end

    // Buffer RAM: synchronous read on the ACK entry edge, byte-enabled write
    always_ff @(posedge wb_clk_i) begin
        buf_q <= bufmem[rd_word[4:0]];
        if (commit && lat_adr[5]) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_sel[b]) bufmem[lat_adr[4:0]][8*b +: 8] <= lat_dat[8*b +: 8];
            end
        end
    end

    assign wbs_dat_o = sel_buf_q ? buf_q : reg_q;

endmodule

// File: tb/tb_mprj_wb_responder.sv
// Directed self-checking bench for mprj_wb_responder.
module tb_mprj_wb_responder;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dati;
    logic        ack;
    logic [31:0] dato;
    logic        irq;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_wr   = 8'd0;

    mprj_wb_responder #(.BASE_ADR(BASE)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dati),
        .wbs_ack_o (ack),
        .wbs_dat_o (dato),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request and wait up to 'budget' cycles for ack.
    // Returns one cycle after the ack cycle (i.e. in the IDLE cycle).
    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int budget,
                        output logic [31:0] rdat, output int lat, output bit acked);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dati = d;
        acked = 1'b0; lat = 0; rdat = '0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1; lat = c; rdat = dato;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (acked) begin
            @(posedge clk); #1;
            check("ack_one_cycle", {31'b0, ack}, 32'd0);
            check("dat_zero_after_ack", dato, 32'd0);
        end
    endtask

    task automatic wr(input string tag, input logic [7:0] off, input logic [3:0] s,
                      input logic [31:0] d);
        logic [31:0] r;
        int          l;
        bit          a;
        xfer(1'b1, BASE + {24'b0, off}, s, d, 40, r, l, a);
        check({tag, "_ack"}, {31'b0, a}, 32'd1);
        if (a) exp_wr++;
    endtask

    task automatic rd(input string tag, input logic [7:0] off, input logic [31:0] exp,
                      input int exp_lat);
        logic [31:0] r;
        int          l;
        bit          a;
        xfer(1'b0, BASE + {24'b0, off}, 4'hF, 32'd0, 40, r, l, a);
        check({tag, "_data"}, r, exp);
        check({tag, "_lat"}, l, exp_lat);
    endtask

    initial begin
        logic [31:0] r;
        int          l;
        bit          a;
        bit          saw_ack;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = '0; dati = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_dat", dato, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);

        // Reset contents, ws=0 -> ack one cycle after sampling
        rd("rst_ctrl",    8'h00, 32'h0, 1);
        rd("rst_status",  8'h04, 32'h0, 1);
        rd("rst_scratch", 8'h08, 32'h0, 1);
        rd("rst_timer",   8'h0C, 32'h0, 1);

        // Byte-select on SCRATCH, write counter
        wr("scr_w", 8'h08, 4'b0101, 32'hDEADBEEF);
        rd("scr_r", 8'h08, 32'h00AD00EF, 1);
        rd("status_cnt1", 8'h04, 32'h0000_0100, 1);

        // Five wait states, BUF write/read
        wr("ctrl_51", 8'h00, 4'hF, 32'h0000_0051);
        wr("buf3_w", 8'h8C, 4'hF, 32'h12345678);
        rd("buf3_r", 8'h8C, 32'h12345678, 6);
        rd("ctrl_r", 8'h00, 32'h0000_0051, 6);

        // Timer expiry -> irq three edges after the load edge
        wr("ctrl_01", 8'h00, 4'hF, 32'h0000_0001);
        wr("tmr3", 8'h0C, 4'hF, 32'd3);
        check("irq_t0", {31'b0, irq}, 32'd0);
        @(posedge clk); #1 check("irq_t1", {31'b0, irq}, 32'd0);
        @(posedge clk); #1 check("irq_t2", {31'b0, irq}, 32'd0);
        @(posedge clk); #1 check("irq_t3", {31'b0, irq}, 32'd1);
        wr("w1c", 8'h04, 4'hF, 32'd1);
        check("irq_cleared", {31'b0, irq}, 32'd0);

        // W1C commits on the very edge the timer expires: set wins
        wr("tmr2", 8'h0C, 4'hF, 32'd2);
        wr("w1c_race", 8'h04, 4'hF, 32'd1);
        check("irq_race", {31'b0, irq}, 32'd1);
        @(posedge clk); #1 check("irq_race_hold", {31'b0, irq}, 32'd1);
        wr("w1c_2", 8'h04, 4'hF, 32'd1);
        check("irq_cleared2", {31'b0, irq}, 32'd0);

        // Abort in WAIT with ws=4
        wr("ctrl_40", 8'h00, 4'hF, 32'h0000_0040);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h08; sel = 4'hF; dati = 32'h1111_1111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        saw_ack = ack;
        stb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) saw_ack = 1'b1;
        end
        cyc = 1'b0; we = 1'b0;
        check("abort_no_ack", {31'b0, saw_ack}, 32'd0);
        rd("abort_scr", 8'h08, 32'h00AD00EF, 5);

        // Outside the window
        xfer(1'b1, BASE + 32'h100, 4'hF, 32'hFFFF_FFFF, 32, r, l, a);
        check("nohit_ack", {31'b0, a}, 32'd0);

        // Write counter wraps after 256 reserved-offset writes
        wr("ctrl_00", 8'h00, 4'hF, 32'h0000_0000);
        rd("status_pre", 8'h04, {16'b0, exp_wr, 8'b0}, 1);
        for (int i = 0; i < 256; i++) begin
            xfer(1'b1, BASE + 32'h10, 4'hF, i, 40, r, l, a);
            if (!a) check("rsv_w_ack", {31'b0, a}, 32'd1);
            else exp_wr++;
        end
        rd("status_wrap", 8'h04, {16'b0, exp_wr, 8'b0}, 1);
        rd("rsv_r", 8'h10, 32'h0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
